// File: rtl/mem_dumper.sv
// mem_dumper: on entry to the DUMP_MEM status, reads sample RAM words
// 0..i_memory_size-1 and streams each word MSB byte first to the UART
// transmitter. A start/done handshake paces the bytes, and o_end reports
// completion to the IAGC controller.
module mem_dumper #(
  parameter int DATA_SIZE        = 16,
  parameter int ADDR_SIZE        = 12,
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int END_CYCLES       = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  input  logic [ADDR_SIZE-1:0]        i_memory_size,
  output logic [ADDR_SIZE-1:0]        o_addr,
  output logic                        o_rd_en,
  input  logic [DATA_SIZE-1:0]        i_data,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_tx_done,
  output logic                        o_end
);

  localparam int BYTES  = DATA_SIZE / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int ECNT_W = $clog2(END_CYCLES + 1);

  localparam logic [IAGC_STATUS_SIZE-1:0] DUMP_MEM  = IAGC_STATUS_SIZE'(7);
  localparam logic [BCNT_W-1:0]           LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [ECNT_W-1:0]           LAST_END  = ECNT_W'(END_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_WAIT_DONE,
    S_END
  } state_t;

  state_t                 state_reg,    state_next;
  logic [ADDR_SIZE-1:0]   addr_reg,     addr_next;
  logic [DATA_SIZE-1:0]   shift_reg,    shift_next;
  logic [BCNT_W-1:0]      byte_cnt_reg, byte_cnt_next;
  logic [ECNT_W-1:0]      end_cnt_reg,  end_cnt_next;
  logic                   dump_reg;

  logic                   dump_now;
  logic                   trigger;
  logic [ADDR_SIZE-1:0]   last_addr;

  assign dump_now  = (i_iagc_status == DUMP_MEM);
  // Only a fresh entry into DUMP_MEM starts a dump; holding it does not.
  assign trigger   = dump_now && !dump_reg;
  assign last_addr = i_memory_size - ADDR_SIZE'(1);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      end_cnt_reg  <= '0;
      dump_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      shift_reg    <= shift_next;
      byte_cnt_reg <= byte_cnt_next;
      end_cnt_reg  <= end_cnt_next;
      dump_reg     <= dump_now;
    end
  end

  // Next-state and datapath update; leaving DUMP_MEM aborts from any busy state.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    shift_next    = shift_reg;
    byte_cnt_next = byte_cnt_reg;
    end_cnt_next  = end_cnt_reg;

    if (state_reg != S_IDLE && !dump_now) begin
      // Abort wins over a coincident i_tx_done.
      state_next    = S_IDLE;
      addr_next     = '0;
      shift_next    = '0;
      byte_cnt_next = '0;
      end_cnt_next  = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          addr_next = '0;
          if (trigger) begin
            end_cnt_next = '0;
            if (i_memory_size == '0) begin
              state_next = S_END;
            end else begin
              state_next = S_READ;
            end
          end
        end
        S_READ: begin
          state_next = S_LATCH;
        end
        S_LATCH: begin
          // RAM data is valid the cycle after the read strobe.
          shift_next    = i_data;
          byte_cnt_next = LAST_BYTE;
          state_next    = S_SEND;
        end
        S_SEND: begin
          state_next = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_tx_done) begin
            if (byte_cnt_reg != '0) begin
              shift_next    = shift_reg << 8;
              byte_cnt_next = byte_cnt_reg - BCNT_W'(1);
              state_next    = S_SEND;
            end else if (addr_reg == last_addr) begin
              addr_next    = '0;
              end_cnt_next = '0;
              state_next   = S_END;
            end else begin
              addr_next  = addr_reg + ADDR_SIZE'(1);
              state_next = S_READ;
            end
          end
        end
        S_END: begin
          addr_next = '0;
          if (end_cnt_reg == LAST_END) begin
            end_cnt_next = '0;
            state_next   = S_IDLE;
          end else begin
            end_cnt_next = end_cnt_reg + ECNT_W'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode purely from registered state; no input reaches them.
  always_comb begin
    o_addr     = addr_reg;
    o_rd_en    = (state_reg == S_READ);
    o_tx_start = (state_reg == S_SEND);
    o_end      = (state_reg == S_END);
    o_tx_data  = 8'h00;
    if (state_reg == S_SEND || state_reg == S_WAIT_DONE) begin
      o_tx_data = shift_reg[DATA_SIZE-1 -: 8];
    end
  end

endmodule

// File: tb/tb_mem_dumper.sv
// tb_mem_dumper: randomized scoreboard bench for mem_dumper. A reference
// model turns RAM contents and dump size into expected read addresses,
// byte stream and end pulses; monitor processes pop and compare them.
module tb_mem_dumper;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int SW = 4;
  localparam int EC = 4;
  localparam int NB = DW / 8;

  localparam logic [SW-1:0] ST_DUMP  = 4'b0111;
  localparam logic [SW-1:0] ST_RESET = 4'b0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] status;
  logic [AW-1:0] mem_size;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done;
  logic          dump_end;

  always #5 clk = ~clk;

  mem_dumper #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .IAGC_STATUS_SIZE(SW), .END_CYCLES(EC)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_iagc_status(status),
    .i_memory_size(mem_size), .o_addr(addr), .o_rd_en(rd_en),
    .i_data(rdata), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_done(tx_done), .o_end(dump_end)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard state
  logic [7:0]    exp_bytes[$];
  logic [AW-1:0] exp_addrs[$];
  int            ends_expected = 0;
  int            start_total = 0;
  int            rd_total = 0;

  // Behavioural RAM contents
  logic [DW-1:0] ram [0:(1<<AW)-1];

  // TX responder controls
  int   tx_delay = 10;
  int   pending = 0;
  logic tx_hold = 1'b0;
  logic tx_force = 1'b0;
  logic spur_en = 1'b0;

  // RAM responder state
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  // Monitor state
  int         end_run = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] last_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: a dump of n words emits words 0..n-1 MSB byte first.
  // max_bytes truncates the stream (abort); with_end adds one end pulse.
  task automatic push_dump(input int n, input int max_bytes, input bit with_end);
    int emitted;
    logic [DW-1:0] w;
    emitted = 0;
    for (int a = 0; a < n; a++) begin
      if (emitted >= max_bytes) break;
      exp_addrs.push_back(AW'(a));
      w = ram[a];
      for (int b = NB - 1; b >= 0; b--) begin
        if (emitted < max_bytes) begin
          exp_bytes.push_back(w[b*8 +: 8]);
          emitted++;
        end
      end
    end
    if (with_end) ends_expected++;
  endtask

  task automatic fill_ram(input int n);
    for (int i = 0; i < n; i++) ram[i] = DW'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_addrs.size() != 0 || ends_expected != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 500);
    check(name, 32'(tx_start), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_end"}, 32'(dump_end), 32'd0);
  endtask

  task automatic start_dump(input int n);
    status = ST_RESET;
    repeat (3) @(negedge clk);
    mem_size = AW'(n);
    status = ST_DUMP;
  endtask

  // RAM model: data appears the cycle after the read strobe, junk otherwise.
  initial begin
    forever begin
      @(negedge clk);
      rdata   = rd_pend ? ram[rd_addr] : DW'($urandom);
      rd_pend = rd_en;
      rd_addr = addr;
    end
  end

  // UART TX model: done pulse tx_delay cycles after each start, plus
  // optional spurious pulses while no byte is in flight.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!tx_force) tx_done = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0 && !tx_force) tx_done = 1'b1;
      end else if (tx_start) begin
        if (!tx_hold) pending = tx_delay;
      end else if (spur_en && !tx_hold && !tx_force && $urandom_range(3) == 0) begin
        tx_done = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe the DUT presents.
  initial begin
    forever begin
      @(negedge clk);
      if (hold_pending && rst_n) check("tx_data_hold", 32'(tx_data), 32'(last_byte));
      hold_pending = 1'b0;
      if (tx_start) begin
        start_total++;
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got byte %0h required no start", tx_data);
        end else begin
          last_byte = exp_bytes.pop_front();
          check("tx_byte", 32'(tx_data), 32'(last_byte));
          $display("tx byte %02h (expected %02h)", tx_data, last_byte);
          hold_pending = 1'b1;
        end
      end
      if (rd_en) begin
        rd_total++;
        if (exp_addrs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got addr %0h required no read", addr);
        end else begin
          check("rd_addr", 32'(addr), 32'(exp_addrs.pop_front()));
        end
      end
      if (dump_end) begin
        end_run++;
        check("end_addr", 32'(addr), 32'd0);
      end else if (end_run > 0) begin
        if (ends_expected == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: got end pulse of %0d cycles required none", end_run);
        end else begin
          check("end_len", 32'(end_run), 32'(EC));
          check("end_after_bytes", 32'(exp_bytes.size()), 32'd0);
          ends_expected--;
          $display("end pulse %0d cycles", end_run);
        end
        end_run = 0;
      end
    end
  end

  // Stimulus
  initial begin
    int base_starts;
    int base_reads;
    int lat;
    rst_n    = 1'b0;
    status   = ST_RESET;
    mem_size = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed dump of three known words, with first-byte latency check
    ram[0] = 16'h1234;
    ram[1] = 16'hABCD;
    ram[2] = 16'h00FF;
    mem_size = AW'(3);
    push_dump(3, 3 * NB, 1'b1);
    status = ST_DUMP;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tx_start && lat < 20);
    check("first_start_latency", 32'(lat), 32'd3);
    wait_done("dump1_complete", 3000);

    // Holding DUMP_MEM must not restart the dump
    base_starts = start_total;
    repeat (200) @(negedge clk);
    check("hold_no_restart", 32'(start_total), 32'(base_starts));

    // Leave and re-enter DUMP_MEM: full second dump
    fill_ram(5);
    push_dump(5, 5 * NB, 1'b1);
    start_dump(5);
    wait_done("dump2_complete", 3000);

    // Zero-size dump: only the end pulse
    base_starts = start_total;
    base_reads  = rd_total;
    push_dump(0, 0, 1'b1);
    start_dump(0);
    wait_done("size0_complete", 200);
    check("size0_no_start", 32'(start_total), 32'(base_starts));
    check("size0_no_read", 32'(rd_total), 32'(base_reads));

    // Abort after the third start, with tx_done in the same cycle
    fill_ram(3);
    push_dump(3, 3, 1'b0);
    start_dump(3);
    wait_start("abort_start1");
    wait_start("abort_start2");
    @(negedge clk);
    tx_hold = 1'b1;
    wait_start("abort_start3");
    @(negedge clk);
    tx_force = 1'b1;
    tx_done  = 1'b1;
    status   = ST_RESET;
    @(negedge clk);
    check_outputs_zero("abort");
    tx_done  = 1'b0;
    tx_force = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("abort_addrs_left", 32'(exp_addrs.size()), 32'd0);
    tx_hold = 1'b0;
    repeat (15) @(negedge clk);

    // Asynchronous reset between clock edges mid-dump
    fill_ram(4);
    push_dump(4, 4 * NB, 1'b1);
    start_dump(4);
    wait_start("rst_start1");
    wait_start("rst_start2");
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    exp_bytes.delete();
    exp_addrs.delete();
    ends_expected = 0;
    status = ST_RESET;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Randomized dumps with spurious tx_done outside WAIT_DONE
    spur_en = 1'b1;
    for (int it = 0; it < 5; it++) begin
      int n;
      n = int'($urandom_range(8, 1));
      tx_delay = int'($urandom_range(12, 1));
      fill_ram(n);
      push_dump(n, n * NB, 1'b1);
      start_dump(n);
      wait_done("rand_dump_complete", 3000);
    end
    spur_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
